// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one signed 8-bit multi-cycle divider between two requesters.
// Short-circuits divide-by-zero and aborts with rsp_err if the divider never signals done.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no operation held; grant a pending requester
// LAUNCH  | operands latched; pulse div_start once the divider is idle
// WAIT    | divider running; watchdog timer counting
// CAPTURE | div_q/div_r valid (one cycle after div_done); latch them
// RESP    | response presented until rsp_ready
module div_share_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_q,
    output logic [7:0] rsp_r,
    output logic       rsp_dz,
    output logic       rsp_err,
    output logic       div_start,
    output logic [7:0] div_a,
    output logic [7:0] div_b,
    input  logic [7:0] div_q,
    input  logic [7:0] div_r,
    input  logic       div_busy,
    input  logic       div_done,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RESP} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       rr_ptr;
    logic [7:0] timer;
    logic [7:0] a_q, b_q;
    logic       id_q;
    logic       grant, winner;
    logic [7:0] win_a, win_b;

    always_comb begin
        winner     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        // reset forces IDLE asynchronously; keep the ready strobes low meanwhile
        grant      = (state == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = grant && !winner;
        req1_ready = grant && winner;
        win_a      = winner ? req1_a : req0_a;
        win_b      = winner ? req1_b : req0_b;
        div_start  = (state == LAUNCH) && !div_busy && !div_done;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
        div_a      = a_q;
        div_b      = b_q;
        rsp_id     = id_q;

        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = (win_b == 8'd0) ? RESP : LAUNCH;
            LAUNCH:  if (div_start) state_nx = WAIT;
            WAIT: begin
                if (div_done)                 state_nx = CAPTURE;
                else if (timer == TIMER_LAST) state_nx = RESP;
            end
            CAPTURE: state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            timer   <= 8'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            id_q    <= 1'b0;
            rsp_q   <= 8'd0;
            rsp_r   <= 8'd0;
            rsp_dz  <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant) begin
                        rr_ptr <= ~winner;
                        id_q   <= winner;
                        a_q    <= win_a;
                        b_q    <= win_b;
                        if (win_b == 8'd0) begin
                            rsp_q   <= 8'd0;
                            rsp_r   <= 8'd0;
                            rsp_dz  <= 1'b1;
                            rsp_err <= 1'b0;
                        end
                    end
                end
                LAUNCH: if (div_start) timer <= 8'd0;
                WAIT: begin
                    if (!div_done) begin
                        if (timer == TIMER_LAST) begin
                            rsp_q   <= 8'd0;
                            rsp_r   <= 8'd0;
                            rsp_dz  <= 1'b0;
                            rsp_err <= 1'b1;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                CAPTURE: begin
                    rsp_q   <= div_q;
                    rsp_r   <= div_r;
                    rsp_dz  <= 1'b0;
                    rsp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter: behavioural divider, expected-response queue,
// per-cycle protocol checks and literal expectations for each scenario.
module tb_div_share_arbiter;

    localparam int TO  = 16;   // must exceed the divider latency so normal divides complete
    localparam int LAT = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_dz, rsp_err;
    logic [7:0] rsp_q, rsp_r;
    logic       div_start, div_busy, div_done, busy;
    logic [7:0] div_a, div_b, div_q, div_r;

    div_share_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_err(rsp_err),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy), .div_done(div_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nvec = 0;
    int nmis = 0;
    int nstart = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_wait(input string name);
        nvec++;
        nmis++;
        $display("FAIL %s: event not seen within budget (cycle %0d)", name, cyc);
    endtask

    // Divider model quotient truncates toward zero; remainder is reported as a magnitude.
    function automatic logic [7:0] fq(input logic signed [7:0] a, input logic signed [7:0] b);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        return 8'(ai / bi);
    endfunction

    function automatic logic [7:0] fr(input logic signed [7:0] a, input logic signed [7:0] b);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (ai < 0) ai = -ai;
        if (bi < 0) bi = -bi;
        return 8'(ai % bi);
    endfunction

    // Shared divider: done L cycles after the start edge, results valid from the edge ending done.
    logic [7:0]        dcnt = 8'd0;
    logic signed [7:0] la = 8'sd0, lb = 8'sd1;
    logic [7:0]        dq = 8'd0, dr = 8'd0;
    bit                hang = 1'b0, force_busy = 1'b0;

    always @(posedge clk) begin
        if (div_start) begin
            dcnt <= 8'(LAT);
            la   <= div_a;
            lb   <= div_b;
            dq   <= 8'hA5;
            dr   <= 8'h5A;
        end else if (dcnt != 8'd0) begin
            dcnt <= dcnt - 8'd1;
            if (dcnt == 8'd1 && !hang) begin
                dq <= fq(la, lb);
                dr <= fr(la, lb);
            end
        end
    end
    assign div_done = (dcnt == 8'd1) && !hang;
    assign div_busy = (dcnt > 8'd1) || force_busy;
    assign div_q    = dq;
    assign div_r    = dr;

    // Expected responses in the order the round-robin rules dictate; kind 0=divide 1=dz 2=err
    typedef struct {
        logic              id;
        logic signed [7:0] a;
        logic signed [7:0] b;
        int                kind;
    } exp_t;
    exp_t expq[$];

    function automatic logic [18:0] exp_rsp(input exp_t e);
        case (e.kind)
            1:       return {e.id, 8'd0, 8'd0, 2'b10};
            2:       return {e.id, 8'd0, 8'd0, 2'b01};
            default: return {e.id, fq(e.a, e.b), fr(e.a, e.b), 2'b00};
        endcase
    endfunction

    logic [18:0] held;
    bit          prev_hold = 1'b0;
    bit          prev_start = 1'b0;
    logic [18:0] cur;

    always @(negedge clk) begin
        cur = {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err};
        if (rst) begin
            chk("reset_outputs",
                {req0_ready, req1_ready, rsp_valid, cur, div_start, div_a, div_b, busy}, 64'd0);
            prev_hold  = 1'b0;
            prev_start = 1'b0;
        end else begin
            chk("ready_rules",
                {req0_ready && req1_ready, req0_ready && !req0_valid, req1_ready && !req1_valid}, 0);
            if (div_start) begin
                nstart++;
                chk("start_divider_idle", {div_busy, div_done}, 2'b00);
                chk("start_one_cycle", prev_start, 1'b0);
                if (expq.size() == 0) fail_wait("start_without_request");
                else chk("start_operands", {div_a, div_b}, {expq[0].a, expq[0].b});
            end
            if (rsp_valid) begin
                if (prev_hold) chk("rsp_stable", cur, held);
                if (rsp_ready) begin
                    if (expq.size() == 0) fail_wait("spurious_rsp");
                    else chk("rsp_model", cur, exp_rsp(expq.pop_front()));
                end
            end
            held       = cur;
            prev_hold  = rsp_valid && !rsp_ready;
            prev_start = div_start;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int port, output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) fail_wait("ready_wait");
    endtask

    task automatic wait_start(output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (div_start) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) fail_wait("start_wait");
    endtask

    task automatic wait_rsp(output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) fail_wait("rsp_wait");
    endtask

    initial begin
        int c0, c1, cs, cr, h, ns;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
        rsp_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // contention with rr_ptr=0: port 0 first, then port 1 right after the handshake
        expq.push_back('{id: 1'b0, a: -8'sd100, b: 8'sd7, kind: 0});
        expq.push_back('{id: 1'b1, a: 8'sd50, b: -8'sd5, kind: 0});
        req0_valid = 1'b1; req0_a = 8'(-100); req0_b = 8'd7;
        req1_valid = 1'b1; req1_a = 8'd50;    req1_b = 8'(-5);
        wait_ready(0, c0);
        step();
        req0_valid = 1'b0;
        wait_rsp(cr);
        chk("rr_first_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b0, 8'hF2, 8'h02, 2'b00});
        wait_ready(1, c1);
        chk("rr_second_accept_cycle", c1, cr + 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(cr);
        chk("rr_second_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b1, 8'hF6, 8'h00, 2'b00});
        step();

        // next contended grant returns to port 0
        expq.push_back('{id: 1'b0, a: 8'sd20, b: 8'sd3, kind: 0});
        expq.push_back('{id: 1'b1, a: 8'sd9, b: 8'sd2, kind: 0});
        req0_valid = 1'b1; req0_a = 8'd20; req0_b = 8'd3;
        req1_valid = 1'b1; req1_a = 8'd9;  req1_b = 8'd2;
        wait_ready(0, c0);
        step();
        req0_valid = 1'b0;
        wait_rsp(cr);
        chk("rr_third_rsp", {rsp_id, rsp_q, rsp_r}, {1'b0, 8'd6, 8'd2});
        wait_ready(1, c1);
        step();
        req1_valid = 1'b0;
        wait_rsp(cr);
        chk("rr_fourth_rsp", {rsp_id, rsp_q, rsp_r}, {1'b1, 8'd4, 8'd1});
        step();

        // basic divide, latency accept->start 1, accept->rsp L+3
        ns = nstart;
        expq.push_back('{id: 1'b0, a: 8'sd100, b: 8'sd7, kind: 0});
        req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd7;
        wait_ready(0, c0);
        step();
        req0_valid = 1'b0;
        wait_start(cs);
        chk("basic_start_latency", cs - c0, 1);
        wait_rsp(cr);
        chk("basic_rsp_latency", cr - c0, LAT + 3);
        chk("basic_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b0, 8'd14, 8'd2, 2'b00});
        step();
        chk("basic_start_count", nstart - ns, 1);

        // divide by zero on port 1: no divider use, response next cycle
        ns = nstart;
        expq.push_back('{id: 1'b1, a: 8'sd33, b: 8'sd0, kind: 1});
        req1_valid = 1'b1; req1_a = 8'd33; req1_b = 8'd0;
        wait_ready(1, c1);
        step();
        req1_valid = 1'b0;
        wait_rsp(cr);
        chk("dz_latency", cr - c1, 1);
        chk("dz_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b1, 8'd0, 8'd0, 2'b10});
        step();
        chk("dz_no_start", nstart - ns, 0);

        // watchdog: hung divider, error TO+1 cycles after start
        hang = 1'b1;
        expq.push_back('{id: 1'b0, a: 8'sd7, b: 8'sd3, kind: 2});
        req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd3;
        wait_ready(0, c0);
        step();
        req0_valid = 1'b0;
        wait_start(cs);
        wait_rsp(cr);
        chk("wd_latency", cr - cs, TO + 1);
        chk("wd_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b0, 8'd0, 8'd0, 2'b01});
        step();
        hang = 1'b0;
        force_busy = 1'b1;
        ns = nstart;
        expq.push_back('{id: 1'b1, a: -8'sd9, b: 8'sd2, kind: 0});
        req1_valid = 1'b1; req1_a = 8'(-9); req1_b = 8'd2;
        wait_ready(1, c1);
        step();
        req1_valid = 1'b0;
        repeat (20) step();
        chk("busy_withholds_start", nstart - ns, 0);
        force_busy = 1'b0;
        wait_start(cs);
        wait_rsp(cr);
        chk("after_wd_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b1, 8'hFC, 8'h01, 2'b00});
        step();

        // backpressure: fields held, req1 refused, then accepted the cycle after the handshake
        expq.push_back('{id: 1'b0, a: 8'sd45, b: 8'sd6, kind: 0});
        expq.push_back('{id: 1'b1, a: -8'sd20, b: -8'sd3, kind: 0});
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd45; req0_b = 8'd6;
        wait_ready(0, c0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'(-20); req1_b = 8'(-3);
        wait_rsp(cr);
        chk("bp_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b0, 8'd7, 8'd3, 2'b00});
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("bp_req1_refused", {req1_ready, rsp_valid}, 2'b01);
        end
        step();
        rsp_ready = 1'b1;
        h = cyc;
        wait_ready(1, c1);
        chk("bp_accept_cycle", c1, h + 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(cr);
        chk("bp_second_rsp", {rsp_id, rsp_q, rsp_r}, {1'b1, 8'd6, 8'd2});
        step();

        // reset while WAIT: outputs clear asynchronously, request dropped
        expq.push_back('{id: 1'b0, a: 8'sd80, b: 8'sd9, kind: 0});
        req0_valid = 1'b1; req0_a = 8'd80; req0_b = 8'd9;
        wait_ready(0, c0);
        step();
        req0_valid = 1'b0;
        wait_start(cs);
        repeat (3) step();
        chk("pre_reset_busy", {busy, rsp_valid}, 2'b10);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err,
             div_start, div_a, div_b, busy}, 64'd0);
        expq.delete();
        repeat (2) step();
        rst = 1'b0;
        expq.push_back('{id: 1'b1, a: -8'sd77, b: 8'sd10, kind: 0});
        req1_valid = 1'b1; req1_a = 8'(-77); req1_b = 8'd10;
        wait_ready(1, c1);
        step();
        req1_valid = 1'b0;
        wait_start(cs);
        wait_rsp(cr);
        chk("post_reset_rsp", {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err}, {1'b1, 8'hF9, 8'h07, 2'b00});
        repeat (3) step();

        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded time budget (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
